// File: rtl/ddr_axi0_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_axi0_arbiter
// Description : Round-robin arbiter that shares DDR controller AXI port 0
//               between the UART capture write path (r0) and the
//               readback/debug read path (r1). Only one transaction is
//               outstanding at a time. The arbiter sequences the address,
//               write-data, write-response and read-data phases and
//               generates WLAST.
//               Optional macro ARB_TIMEOUT_EN adds a handshake watchdog with
//               a sticky o_timeout output.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_axi0_arbiter #(
  parameter logic [7:0] ID0 = 8'h00,
  parameter logic [7:0] ID1 = 8'h01
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  // requester 0 (UART capture write path)
  input  logic         r0_req_valid,
  output logic         r0_req_ready,
  input  logic [31:0]  r0_req_addr,
  input  logic [7:0]   r0_req_len,
  input  logic         r0_req_wr,
  input  logic [255:0] r0_wdata,
  input  logic         r0_wvalid,
  output logic         r0_wready,
  output logic [255:0] r0_rdata,
  output logic         r0_rvalid,
  input  logic         r0_rready,
  output logic         r0_done,
  output logic         r0_err,
  // requester 1 (readback/debug read path)
  input  logic         r1_req_valid,
  output logic         r1_req_ready,
  input  logic [31:0]  r1_req_addr,
  input  logic [7:0]   r1_req_len,
  input  logic         r1_req_wr,
  input  logic [255:0] r1_wdata,
  input  logic         r1_wvalid,
  output logic         r1_wready,
  output logic [255:0] r1_rdata,
  output logic         r1_rvalid,
  input  logic         r1_rready,
  output logic         r1_done,
  output logic         r1_err,
  // status
  output logic [1:0]   o_gnt,
  output logic         o_busy,
  // AXI port 0 combined address channel
  output logic [7:0]   DdrCtrl_AID_0,
  output logic [31:0]  DdrCtrl_AADDR_0,
  output logic [7:0]   DdrCtrl_ALEN_0,
  output logic [2:0]   DdrCtrl_ASIZE_0,
  output logic [1:0]   DdrCtrl_ABURST_0,
  output logic [1:0]   DdrCtrl_ALOCK_0,
  output logic         DdrCtrl_AVALID_0,
  output logic         DdrCtrl_ATYPE_0,
  input  logic         DdrCtrl_AREADY_0,
  // write data channel
  output logic [7:0]   DdrCtrl_WID_0,
  output logic [255:0] DdrCtrl_WDATA_0,
  output logic [31:0]  DdrCtrl_WSTRB_0,
  output logic         DdrCtrl_WLAST_0,
  output logic         DdrCtrl_WVALID_0,
  input  logic         DdrCtrl_WREADY_0,
  // read data channel
  input  logic [7:0]   DdrCtrl_RID_0,
  input  logic [255:0] DdrCtrl_RDATA_0,
  input  logic         DdrCtrl_RLAST_0,
  input  logic         DdrCtrl_RVALID_0,
  input  logic [1:0]   DdrCtrl_RRESP_0,
  output logic         DdrCtrl_RREADY_0,
  // write response channel
  input  logic [7:0]   DdrCtrl_BID_0,
  input  logic         DdrCtrl_BVALID_0,
  output logic         DdrCtrl_BREADY_0
`ifdef ARB_TIMEOUT_EN
  ,
  output logic         o_timeout
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_nextState;

  logic         r_owner;      // 0 = r0, 1 = r1
  logic         r_lastGnt;    // requester granted most recently
  logic         r_wr;
  logic [31:0]  r_addr;
  logic [7:0]   r_len;
  logic [7:0]   r_beatCnt;
  logic         r_errSticky;

  logic         w_grant0;
  logic         w_grant1;
  logic         w_aFire;
  logic         w_wFire;
  logic         w_wLast;
  logic         w_bFire;
  logic         w_rFire;
  logic         w_rDone;
  logic         w_rBeatErr;
  logic         w_unused;

  // IDs are fixed per requester and only one transaction is ever in flight,
  // so the returned RID/BID carry no extra information.
  assign w_unused = &{1'b0, DdrCtrl_RID_0, DdrCtrl_BID_0};

  // On a tie the requester that did not win last time is served;
  // r_lastGnt resets to 1 so r0 wins the first tie.
  assign w_grant0 = (r_state == ST_IDLE) && r0_req_valid && (!r1_req_valid || r_lastGnt);
  assign w_grant1 = (r_state == ST_IDLE) && r1_req_valid && (!r0_req_valid || !r_lastGnt);

  assign w_aFire    = (r_state == ST_ADDR) && DdrCtrl_AREADY_0;
  assign w_wFire    = (r_state == ST_WDATA) && (r_owner ? r1_wvalid : r0_wvalid)
                      && DdrCtrl_WREADY_0;
  assign w_wLast    = (r_beatCnt == r_len);
  assign w_bFire    = (r_state == ST_WRESP) && DdrCtrl_BVALID_0;
  assign w_rFire    = (r_state == ST_RDATA) && DdrCtrl_RVALID_0
                      && (r_owner ? r1_rready : r0_rready);
  assign w_rDone    = w_rFire && DdrCtrl_RLAST_0;
  assign w_rBeatErr = (DdrCtrl_RRESP_0 != 2'b00);

  assign o_busy = (r_state != ST_IDLE);
  assign o_gnt  = (r_state == ST_IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and channel steering for the current owner
  always_comb begin
    w_nextState      = r_state;
    r0_req_ready     = 1'b0;
    r1_req_ready     = 1'b0;
    r0_wready        = 1'b0;
    r1_wready        = 1'b0;
    r0_rdata         = '0;
    r1_rdata         = '0;
    r0_rvalid        = 1'b0;
    r1_rvalid        = 1'b0;
    DdrCtrl_AID_0    = 8'h00;
    DdrCtrl_AADDR_0  = 32'h0;
    DdrCtrl_ALEN_0   = 8'h00;
    DdrCtrl_ASIZE_0  = 3'b000;
    DdrCtrl_ABURST_0 = 2'b00;
    DdrCtrl_ALOCK_0  = 2'b00;
    DdrCtrl_AVALID_0 = 1'b0;
    DdrCtrl_ATYPE_0  = 1'b0;
    DdrCtrl_WID_0    = 8'h00;
    DdrCtrl_WDATA_0  = '0;
    DdrCtrl_WSTRB_0  = 32'h0;
    DdrCtrl_WLAST_0  = 1'b0;
    DdrCtrl_WVALID_0 = 1'b0;
    DdrCtrl_RREADY_0 = 1'b0;
    DdrCtrl_BREADY_0 = 1'b0;

    case (r_state)
      ST_IDLE: begin
        r0_req_ready = w_grant0;
        r1_req_ready = w_grant1;
        if (w_grant0 || w_grant1) begin
          w_nextState = ST_ADDR;
        end
      end

      ST_ADDR: begin
        DdrCtrl_AVALID_0 = 1'b1;
        DdrCtrl_AID_0    = r_owner ? ID1 : ID0;
        DdrCtrl_AADDR_0  = r_addr;
        DdrCtrl_ALEN_0   = r_len;
        DdrCtrl_ASIZE_0  = 3'b101;   // 32-byte beats
        DdrCtrl_ABURST_0 = 2'b01;    // INCR
        DdrCtrl_ATYPE_0  = r_wr;
        if (w_aFire) begin
          w_nextState = r_wr ? ST_WDATA : ST_RDATA;
        end
      end

      ST_WDATA: begin
        DdrCtrl_WID_0    = r_owner ? ID1 : ID0;
        DdrCtrl_WSTRB_0  = 32'hFFFF_FFFF;
        DdrCtrl_WLAST_0  = w_wLast;
        DdrCtrl_WVALID_0 = r_owner ? r1_wvalid : r0_wvalid;
        DdrCtrl_WDATA_0  = r_owner ? r1_wdata : r0_wdata;
        r0_wready        = !r_owner && DdrCtrl_WREADY_0;
        r1_wready        = r_owner && DdrCtrl_WREADY_0;
        if (w_wFire && w_wLast) begin
          w_nextState = ST_WRESP;
        end
      end

      ST_WRESP: begin
        DdrCtrl_BREADY_0 = 1'b1;
        if (w_bFire) begin
          w_nextState = ST_IDLE;
        end
      end

      ST_RDATA: begin
        DdrCtrl_RREADY_0 = r_owner ? r1_rready : r0_rready;
        if (r_owner) begin
          r1_rvalid = DdrCtrl_RVALID_0;
          r1_rdata  = DdrCtrl_RDATA_0;
        end else begin
          r0_rvalid = DdrCtrl_RVALID_0;
          r0_rdata  = DdrCtrl_RDATA_0;
        end
        if (w_rDone) begin
          w_nextState = ST_IDLE;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Latch the winning request and remember who was served
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner   <= 1'b0;
      r_lastGnt <= 1'b1;
      r_addr    <= 32'h0;
      r_len     <= 8'h00;
      r_wr      <= 1'b0;
    end else if (w_grant0 || w_grant1) begin
      r_owner   <= w_grant1;
      r_lastGnt <= w_grant1;
      r_addr    <= w_grant1 ? r1_req_addr : r0_req_addr;
      r_len     <= w_grant1 ? r1_req_len  : r0_req_len;
      r_wr      <= w_grant1 ? r1_req_wr   : r0_req_wr;
    end
  end

  // Write beat counter: zeroed as the address is accepted, steps per beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beatCnt <= 8'h00;
    end else if (w_aFire) begin
      r_beatCnt <= 8'h00;
    end else if (w_wFire) begin
      r_beatCnt <= r_beatCnt + 8'd1;
    end
  end

  // Sticky read error: collects RRESP over a burst, cleared on the last beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_errSticky <= 1'b0;
    end else if (w_rFire) begin
      if (DdrCtrl_RLAST_0) begin
        r_errSticky <= 1'b0;
      end else if (w_rBeatErr) begin
        r_errSticky <= 1'b1;
      end
    end
  end

  // Completion pulses are registered so they coincide with the IDLE cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      r0_err  <= 1'b0;
      r1_err  <= 1'b0;
    end else begin
      r0_done <= (w_bFire || w_rDone) && !r_owner;
      r1_done <= (w_bFire || w_rDone) && r_owner;
      r0_err  <= w_rDone && !r_owner && (r_errSticky || w_rBeatErr);
      r1_err  <= w_rDone && r_owner && (r_errSticky || w_rBeatErr);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int c_wdogWidth = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_wdogWidth-1:0] c_wdogLimit = c_wdogWidth'(TIMEOUT_CYC);
  localparam logic [c_wdogWidth-1:0] c_wdogOne   = c_wdogWidth'(1);

  logic [c_wdogWidth-1:0] r_wdogCnt;
  logic                   w_anyFire;

  assign w_anyFire = w_aFire || w_wFire || w_bFire || w_rFire;

  // Watchdog: count busy cycles with no handshake; flag is sticky until reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdogCnt <= '0;
      o_timeout <= 1'b0;
    end else if ((r_state == ST_IDLE) || w_anyFire) begin
      r_wdogCnt <= '0;
    end else if (r_wdogCnt != c_wdogLimit) begin
      r_wdogCnt <= r_wdogCnt + c_wdogOne;
      if (r_wdogCnt == (c_wdogLimit - c_wdogOne)) begin
        o_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_axi0_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_axi0_arbiter
// Description : Directed self-checking bench for ddr_axi0_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_axi0_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  logic         r0_req_valid, r0_req_ready, r0_req_wr, r0_wvalid, r0_wready;
  logic [31:0]  r0_req_addr;
  logic [7:0]   r0_req_len;
  logic [255:0] r0_wdata, r0_rdata;
  logic         r0_rvalid, r0_rready, r0_done, r0_err;
  logic         r1_req_valid, r1_req_ready, r1_req_wr, r1_wvalid, r1_wready;
  logic [31:0]  r1_req_addr;
  logic [7:0]   r1_req_len;
  logic [255:0] r1_wdata, r1_rdata;
  logic         r1_rvalid, r1_rready, r1_done, r1_err;
  logic [1:0]   gnt;
  logic         busy;
  logic [7:0]   aId, aLen, wId, rId, bId;
  logic [31:0]  aAddr, wStrb;
  logic [2:0]   aSize;
  logic [1:0]   aBurst, aLock, rResp;
  logic         aValid, aType, aReady;
  logic [255:0] wData, rData;
  logic         wLast, wValid, wReady;
  logic         rLast, rValid, rReady, bValid, bReady;
  logic         timeout;
  int           beats;

  ddr_axi0_arbiter #(
    .ID0(8'h00),
    .ID1(8'h01)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
    .r0_req_len(r0_req_len), .r0_req_wr(r0_req_wr), .r0_wdata(r0_wdata),
    .r0_wvalid(r0_wvalid), .r0_wready(r0_wready), .r0_rdata(r0_rdata),
    .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
    .r1_req_len(r1_req_len), .r1_req_wr(r1_req_wr), .r1_wdata(r1_wdata),
    .r1_wvalid(r1_wvalid), .r1_wready(r1_wready), .r1_rdata(r1_rdata),
    .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_done(r1_done), .r1_err(r1_err),
    .o_gnt(gnt), .o_busy(busy),
    .DdrCtrl_AID_0(aId), .DdrCtrl_AADDR_0(aAddr), .DdrCtrl_ALEN_0(aLen),
    .DdrCtrl_ASIZE_0(aSize), .DdrCtrl_ABURST_0(aBurst), .DdrCtrl_ALOCK_0(aLock),
    .DdrCtrl_AVALID_0(aValid), .DdrCtrl_ATYPE_0(aType), .DdrCtrl_AREADY_0(aReady),
    .DdrCtrl_WID_0(wId), .DdrCtrl_WDATA_0(wData), .DdrCtrl_WSTRB_0(wStrb),
    .DdrCtrl_WLAST_0(wLast), .DdrCtrl_WVALID_0(wValid), .DdrCtrl_WREADY_0(wReady),
    .DdrCtrl_RID_0(rId), .DdrCtrl_RDATA_0(rData), .DdrCtrl_RLAST_0(rLast),
    .DdrCtrl_RVALID_0(rValid), .DdrCtrl_RRESP_0(rResp), .DdrCtrl_RREADY_0(rReady),
    .DdrCtrl_BID_0(bId), .DdrCtrl_BVALID_0(bValid), .DdrCtrl_BREADY_0(bReady)
`ifdef ARB_TIMEOUT_EN
    ,
    .o_timeout(timeout)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    r0_req_valid = 0; r0_req_addr = 0; r0_req_len = 0; r0_req_wr = 0;
    r0_wdata = '0; r0_wvalid = 0; r0_rready = 0;
    r1_req_valid = 0; r1_req_addr = 0; r1_req_len = 0; r1_req_wr = 0;
    r1_wdata = '0; r1_wvalid = 0; r1_rready = 0;
    aReady = 0; wReady = 0; rId = 0; rData = '0; rLast = 0; rValid = 0;
    rResp = 0; bId = 0; bValid = 0;
  endtask

  // Global time bound so a stuck handshake cannot hang the run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "time bound exceeded");
  end

  initial begin
    clearInputs();
    rst_n = 0;
    tick(); tick();
    // ---- reset state
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_avalid", aValid, 0);
    chk("rst_wvalid", wValid, 0);
    chk("rst_bready", bReady, 0);
    chk("rst_done0", r0_done, 0);
    rst_n = 1;
    tick();

    // ---- A: r0 write addr 0x100 len 3, r1 request waits while busy
    r0_req_valid = 1; r0_req_addr = 32'h100; r0_req_len = 3; r0_req_wr = 1; #1;
    chk("A_ready0", r0_req_ready, 1);
    chk("A_ready1", r1_req_ready, 0);
    chk("A_gnt_idle", gnt, 2'b00);
    tick();
    r0_req_valid = 0;
    r1_req_valid = 1; r1_req_addr = 32'h300; r1_req_len = 0; r1_req_wr = 0; #1;
    chk("A_avalid", aValid, 1);
    chk("A_aaddr", aAddr, 32'h100);
    chk("A_alen", aLen, 3);
    chk("A_aid", aId, 8'h00);
    chk("A_atype", aType, 1);
    chk("A_asize", aSize, 3'b101);
    chk("A_aburst", aBurst, 2'b01);
    chk("A_alock", aLock, 2'b00);
    chk("A_gnt", gnt, 2'b01);
    chk("A_r1_wait", r1_req_ready, 0);
    aReady = 1;
    tick();
    aReady = 0; #1;
    chk("A_avalid_drop", aValid, 0);
    wReady = 1; r0_wvalid = 1;
    for (int i = 0; i < 4; i++) begin
      r0_wdata = {8{32'hC0DE_0000 + 32'(i)}}; #1;
      chk("A_wvalid", wValid, 1);
      chk("A_wdata", wData, {8{32'hC0DE_0000 + 32'(i)}});
      chk("A_wlast", wLast, (i == 3));
      chk("A_wid", wId, 8'h00);
      chk("A_wstrb", wStrb, 32'hFFFF_FFFF);
      chk("A_wready0", r0_wready, 1);
      chk("A_wready1", r1_wready, 0);
      tick();
    end
    r0_wvalid = 0; wReady = 0; #1;
    chk("A_bready", bReady, 1);
    chk("A_wvalid_resp", wValid, 0);
    chk("A_r1_still_wait", r1_req_ready, 0);
    bValid = 1; #1;
    chk("A_done_not_yet", r0_done, 0);
    tick();
    bValid = 0; #1;
    chk("A_done0", r0_done, 1);
    chk("A_busy_idle", busy, 0);
    chk("A_r1_granted", r1_req_ready, 1);
    tick();
    r1_req_valid = 0; #1;
    chk("A_done0_pulse", r0_done, 0);
    chk("A_gnt_r1", gnt, 2'b10);
    chk("A_aid_r1", aId, 8'h01);
    rst_n = 0; clearInputs();
    tick();
    rst_n = 1;
    tick();

    // ---- B: simultaneous requests after reset alternate r0,r1,r0,r1
    for (int i = 0; i < 4; i++) begin
      r0_req_valid = 1; r0_req_addr = 32'h400; r0_req_len = 0; r0_req_wr = 0;
      r1_req_valid = 1; r1_req_addr = 32'h500; r1_req_len = 0; r1_req_wr = 0;
      r0_rready = 1; r1_rready = 1; #1;
      chk("B_ready0", r0_req_ready, (i % 2 == 0));
      chk("B_ready1", r1_req_ready, (i % 2 == 1));
      tick();
      r0_req_valid = 0; r1_req_valid = 0; #1;
      chk("B_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      aReady = 1;
      tick();
      aReady = 0;
      rValid = 1; rLast = 1; rResp = 0; rData = {8{32'(i)}}; #1;
      chk("B_rvalid_owner", (i % 2 == 0) ? r0_rvalid : r1_rvalid, 1);
      chk("B_rvalid_other", (i % 2 == 0) ? r1_rvalid : r0_rvalid, 0);
      tick();
      rValid = 0; rLast = 0; #1;
      chk("B_done", (i % 2 == 0) ? r0_done : r1_done, 1);
      chk("B_err", {r0_err, r1_err}, 2'b00);
    end
    r0_rready = 0; r1_rready = 0;
    tick();

    // ---- C: r1 read len 0 with RRESP=2'b10 on the only beat
    r1_req_valid = 1; r1_req_addr = 32'h200; r1_req_len = 0; r1_req_wr = 0; #1;
    chk("C_ready1", r1_req_ready, 1);
    tick();
    r1_req_valid = 0; #1;
    chk("C_aid", aId, 8'h01);
    chk("C_atype", aType, 0);
    chk("C_alen", aLen, 0);
    aReady = 1;
    tick();
    aReady = 0;
    rValid = 1; rLast = 1; rResp = 2'b10; rData = {8{32'hDEAD_BEEF}}; r1_rready = 1; #1;
    chk("C_rvalid1", r1_rvalid, 1);
    chk("C_rdata1", r1_rdata, {8{32'hDEAD_BEEF}});
    chk("C_rvalid0", r0_rvalid, 0);
    chk("C_rready", rReady, 1);
    tick();
    rValid = 0; rLast = 0; rResp = 0; #1;
    chk("C_done1", r1_done, 1);
    chk("C_err1", r1_err, 1);
    chk("C_rvalid_after", r1_rvalid, 0);
    tick();
    chk("C_done_pulse", r1_done, 0);
    chk("C_err_pulse", r1_err, 0);
    r1_rready = 0;

    // ---- C2: r0 read len 1, error on the first beat only, stall before it
    r0_req_valid = 1; r0_req_addr = 32'h600; r0_req_len = 1; r0_req_wr = 0; #1;
    tick();
    r0_req_valid = 0; aReady = 1;
    tick();
    aReady = 0;
    rValid = 1; rLast = 0; rResp = 2'b01; r0_rready = 0; #1;
    chk("C2_rready_stall", rReady, 0);
    tick();
    r0_rready = 1; #1;
    chk("C2_rready", rReady, 1);
    tick();
    rResp = 2'b00; rLast = 1;
    tick();
    rValid = 0; rLast = 0; #1;
    chk("C2_done0", r0_done, 1);
    chk("C2_err0", r0_err, 1);
    r0_rready = 0;
    // clean read afterwards must report no error
    r1_req_valid = 1; r1_req_addr = 32'h700; r1_req_len = 0; r1_req_wr = 0; #1;
    tick();
    r1_req_valid = 0; aReady = 1;
    tick();
    aReady = 0; rValid = 1; rLast = 1; rResp = 0; r1_rready = 1;
    tick();
    rValid = 0; rLast = 0; r1_rready = 0; #1;
    chk("C3_done1", r1_done, 1);
    chk("C3_err1_clear", r1_err, 0);

    // ---- D: r0 write len 255, WREADY toggling
    r0_req_valid = 1; r0_req_addr = 32'h1000; r0_req_len = 8'd255; r0_req_wr = 1; #1;
    chk("D_ready0", r0_req_ready, 1);
    tick();
    r0_req_valid = 0; aReady = 1;
    tick();
    aReady = 0; r0_wvalid = 1;
    beats = 0;
    for (int cyc = 0; cyc < 600 && bReady == 1'b0; cyc++) begin
      wReady = (cyc % 2 == 0);
      r0_wdata = 256'(beats); #1;
      if (wValid && wReady) begin
        chk("D_wlast", wLast, (beats == 255));
        chk("D_wdata", wData, 256'(beats));
        beats++;
      end
      tick();
    end
    r0_wvalid = 0; wReady = 0; #1;
    chk("D_beats", beats, 256);
    chk("D_bready", bReady, 1);
    bValid = 1;
    tick();
    bValid = 0; #1;
    chk("D_done0", r0_done, 1);

    // ---- E: reset in the middle of WDATA at beat 2
    r0_req_valid = 1; r0_req_addr = 32'h2000; r0_req_len = 3; r0_req_wr = 1; #1;
    tick();
    r0_req_valid = 0; aReady = 1;
    tick();
    aReady = 0; wReady = 1; r0_wvalid = 1;
    tick(); tick();
    chk("E_in_wdata", wValid, 1);
    chk("E_wlast_b2", wLast, 0);
    rst_n = 0; clearInputs();
    tick();
    chk("E_gnt", gnt, 2'b00);
    chk("E_busy", busy, 0);
    chk("E_wvalid", wValid, 0);
    chk("E_avalid", aValid, 0);
    chk("E_wready0", r0_wready, 0);
    chk("E_bready", bReady, 0);
    chk("E_done0", r0_done, 0);
    rst_n = 1;
    tick();
    r1_req_valid = 1; r1_req_addr = 32'h3000; r1_req_len = 0; r1_req_wr = 0; #1;
    chk("E_ready1", r1_req_ready, 1);
    chk("E_ready0", r0_req_ready, 0);
    tick();
    r1_req_valid = 0; #1;
    chk("E_gnt_r1", gnt, 2'b10);
    rst_n = 0; clearInputs();
    tick();
    rst_n = 1;
    tick();

`ifdef ARB_TIMEOUT_EN
    // ---- F: AREADY held low, watchdog limit 16
    r0_req_valid = 1; r0_req_addr = 32'h4000; r0_req_len = 0; r0_req_wr = 1; #1;
    tick();
    r0_req_valid = 0;
    repeat (15) tick();
    chk("F_timeout_early", timeout, 0);
    tick();
    chk("F_timeout", timeout, 1);
    chk("F_avalid", aValid, 1);
`else
    chk("F_no_timeout", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_axi0_arbiter.md
Name: ddr_axi0_arbiter

Overview:
- Shares the single DDR controller AXI4 port 0 (combined address channel with ATYPE) between two requesters: r0 = UART capture write path, r1 = readback/debug read path.
- Round-robin arbitration; exactly one transaction outstanding at a time.
- Generates the address/write/response/read sequencing and WLAST.
- Sits between TOP_DESIGN-side requesters and the DdrCtrl_*_0 pins, in the Axi0Clk domain.

Parameters:
- ID0, 8'h00, AID/WID driven for r0 transactions
- ID1, 8'h01, AID/WID driven for r1 transactions
- TIMEOUT_CYC, 4096, watchdog limit (used only with the optional feature)

Ports:
- i_clk  in  1  Axi0Clk-domain clock
- i_rst_n  in  1  asynchronous active-low reset
- rN_req_valid  in  1  command valid, N in {0,1}; held until rN_req_ready
- rN_req_ready  out  1  command accepted (1-cycle pulse)
- rN_req_addr  in  32  byte address
- rN_req_len  in  8  beats minus 1
- rN_req_wr  in  1  1=write, 0=read
- rN_wdata  in  256  write beat
- rN_wvalid  in  1  write beat valid
- rN_wready  out  1  write beat accepted
- rN_rdata  out  256  read beat
- rN_rvalid  out  1  read beat valid
- rN_rready  in  1  requester can take read beat
- rN_done  out  1  1-cycle pulse at transaction end
- rN_err  out  1  pulse with rN_done if any RRESP!=0 during the read
- o_gnt  out  2  one-hot current owner, 0 in IDLE
- o_busy  out  1  state!=IDLE
- DdrCtrl_AID_0/AADDR_0/ALEN_0/ASIZE_0/ABURST_0/ALOCK_0/AVALID_0/ATYPE_0  out  8/32/8/3/2/2/1/1  address channel
- DdrCtrl_AREADY_0  in  1
- DdrCtrl_WID_0/WDATA_0/WSTRB_0/WLAST_0/WVALID_0  out  8/256/32/1/1  write channel
- DdrCtrl_WREADY_0  in  1
- DdrCtrl_RID_0/RDATA_0/RLAST_0/RVALID_0/RRESP_0  in  8/256/1/1/2  read channel
- DdrCtrl_RREADY_0  out  1
- DdrCtrl_BID_0/BVALID_0  in  8/1
- DdrCtrl_BREADY_0  out  1

Behaviour:
- Reset: state IDLE; all outputs 0; last_gnt=1, so r0 wins the first tie.
- FSM: IDLE -> ADDR -> (WDATA -> WRESP | RDATA) -> IDLE.
- IDLE arbitration:
  - Only one rN_req_valid asserted: grant it.
  - Both asserted: grant the requester that is not last_gnt.
  - On grant: pulse rN_req_ready that cycle, latch addr/len/wr, update last_gnt, go to ADDR.
- ADDR:
  - AVALID=1 with latched fields; AID=IDn; ATYPE=wr; ASIZE=3'b101; ABURST=2'b01; ALOCK=0.
  - Fields stay stable until AREADY.
  - AVALID&AREADY -> WDATA if write, else RDATA. AVALID drops the next cycle.
- WDATA:
  - WVALID=rN_wvalid of the owner; rN_wready=WREADY; WDATA passed combinationally; WSTRB=32'hFFFF_FFFF; WID=IDn.
  - 8-bit beat counter cleared on entry. WLAST=(cnt==len). cnt increments per WVALID&WREADY.
  - Last-beat handshake -> WRESP. Non-owner wready=0.
- WRESP: BREADY=1. On BVALID -> IDLE, pulse rN_done.
- RDATA:
  - rN_rvalid=RVALID (owner only); RREADY=rN_rready; rdata passed through.
  - Sticky error bit set if RRESP!=0 on any accepted beat.
  - RVALID&RREADY&RLAST -> IDLE, pulse rN_done; rN_err=sticky bit; sticky bit cleared on exit.
- Latency: grant to AVALID = 1 cycle. Back-to-back transactions lose one IDLE cycle each.
- Boundaries:
  - len=0 gives a single beat with WLAST on the first beat.
  - len=255 gives 256 beats; the counter never wraps before WLAST.
  - A request arriving while busy waits; a requester that makes a new request in the same cycle as its own rN_done is arbitrated normally on the next IDLE cycle.
- Reset mid-transaction: immediate return to IDLE with outputs 0. The DDR controller is reset in parallel via CFG_RST_N by the system; no drain is attempted.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - Watchdog counts cycles in ADDR/WDATA/WRESP/RDATA without any channel handshake; it is cleared on every handshake.
  - When it reaches TIMEOUT_CYC, sticky output o_timeout goes 1 (cleared only by reset).
  - FSM is not aborted.
- Undefined: no o_timeout port, no counter logic.

Test Plan:
- r0 write addr=32'h100, len=3, WREADY always 1 -> AVALID 1 cycle after grant; 4 W beats with WLAST on beat 4; AID=WID=8'h00; r0_done 1 cycle after BVALID.
- r0 and r1 both request in the same cycle after reset, repeated 4 times -> grant order r0,r1,r0,r1.
- r1 read len=0, RRESP=2'b10 on the single RLAST beat -> r1_rvalid 1 beat; r1_done=1 and r1_err=1 in the same cycle.
- Write len=255 with WREADY toggling every cycle -> exactly 256 accepted beats; WLAST only on the 256th accepted beat.
- Assert i_rst_n=0 mid-WDATA at beat 2 -> next edge all outputs 0, o_gnt=0; a new r1 request after release is granted first (last_gnt=1, r1 alone).
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=16, hold AREADY=0 -> o_timeout=1 after 16 cycles in ADDR; AVALID still 1.
